cp0_timer_ext: RTL and testbench

//  Parametrised coprocessor-0 for the pipelined MIPS core. It sits beside the M stage.

---
 rtl/cp0_timer_ext.sv | 167 ++++++++++++++++
 tb/tb_cp0_timer_ext.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer_ext.sv
// Coprocessor-0 with SR/Cause/EPC/PRId, Count/Compare timer and a
// configurable set of level- or edge-triggered hardware interrupt lines.
module cp0_timer_ext #(
    parameter int unsigned          N_HWINT   = 6,
    parameter logic [N_HWINT-1:0]   EDGE_MASK = '0,
    parameter logic [31:0]          PRID_VAL  = 32'h2001_0616
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          rd_addr,
    input  logic [4:0]          wr_addr,
    input  logic [31:0]         wr_data,
    input  logic                we,
    input  logic [29:0]         pc,
    input  logic [4:0]          exc_code,
    input  logic                bd_in,
    input  logic                exl_clr,
    input  logic [N_HWINT-1:0]  hw_int,
    output logic                int_exc_req,
    output logic [31:0]         epc,
    output logic [31:0]         rd_data,
    output logic                timer_irq
);

    localparam int unsigned L = N_HWINT + 1;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    logic [L-1:0]       im;
    logic               exl;
    logic               ie;
    logic               bd;
    logic [L-1:0]       ip;
    logic [4:0]         exc_code_r;
    logic [29:0]        epc_r;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               armed;
    logic               timer_lat;
    logic [N_HWINT-1:0] edge_lat;
    logic [N_HWINT-1:0] prev;

    logic [L-1:0]       pend;
    logic               int_req;
    logic               exc_req;
    logic               take;
    logic               wr_ok;
    logic [N_HWINT-1:0] rise;
    logic [N_HWINT-1:0] keep;
    logic [31:0]        sr_val;
    logic [31:0]        cause_val;

    // Pending vector, request decode and edge-latch next-state terms
    always_comb begin
        pend              = '0;
        pend[N_HWINT-1:0] = (edge_lat & EDGE_MASK) | (hw_int & ~EDGE_MASK);
        pend[N_HWINT]     = timer_lat;
        int_req           = ~exl & ie & (|(pend & im));
        exc_req           = ~exl & (exc_code != 5'd0);
        take              = int_req | exc_req;
        // an mtc0 coinciding with a take is discarded
        wr_ok             = we & ~take;
        rise              = hw_int & ~prev & EDGE_MASK;
        keep              = '1;
        if (wr_ok && wr_addr == REG_CAUSE) begin
            keep = wr_data[10 +: N_HWINT] | ~EDGE_MASK;
        end
    end

    assign int_exc_req = take;
    assign epc         = {epc_r, 2'b00};
    assign timer_irq   = timer_lat;

    // Assemble SR/Cause views and the combinational mfc0 read mux
    always_comb begin
        sr_val              = '0;
        sr_val[9+L:10]      = im;
        sr_val[1]           = exl;
        sr_val[0]           = ie;
        cause_val           = '0;
        cause_val[31]       = bd;
        cause_val[9+L:10]   = ip;
        cause_val[6:2]      = exc_code_r;
        case (rd_addr)
            REG_COUNT:   rd_data = count;
            REG_COMPARE: rd_data = compare;
            REG_SR:      rd_data = sr_val;
            REG_CAUSE:   rd_data = cause_val;
            REG_EPC:     rd_data = epc;
            REG_PRID:    rd_data = PRID_VAL;
            default:     rd_data = 32'd0;
        endcase
    end

    // Status, cause and EPC: a take overrides eret and any mtc0
    always_ff @(posedge clk) begin
        if (reset) begin
            im         <= '0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            ip         <= '0;
            exc_code_r <= 5'd0;
            epc_r      <= 30'd0;
        end else begin
            ip <= pend;
            if (take) begin
                exl        <= 1'b1;
                bd         <= bd_in;
                exc_code_r <= int_req ? 5'd0 : exc_code;
                epc_r      <= bd_in ? (pc - 30'd1) : pc;
            end else begin
                if (exl_clr) begin
                    exl <= 1'b0;
                end
                if (wr_ok && wr_addr == REG_SR) begin
                    im  <= wr_data[9+L:10];
                    exl <= wr_data[1];
                    ie  <= wr_data[0];
                end
                if (wr_ok && wr_addr == REG_EPC) begin
                    epc_r <= wr_data[31:2];
                end
            end
        end
    end

    // Count/Compare timer; a Compare write clears the latch and re-arms
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 32'd0;
            compare   <= 32'd0;
            armed     <= 1'b0;
            timer_lat <= 1'b0;
        end else begin
            if (wr_ok && wr_addr == REG_COUNT) begin
                count <= wr_data;
            end else begin
                count <= count + 32'd1;
            end
            if (wr_ok && wr_addr == REG_COMPARE) begin
                compare   <= wr_data;
                armed     <= 1'b1;
                timer_lat <= 1'b0;
            end else if (armed && count == compare) begin
                timer_lat <= 1'b1;
            end
        end
    end

    // Edge-line capture: a rising edge wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_lat <= '0;
            prev     <= '0;
        end else begin
            edge_lat <= ((edge_lat & keep) | rise) & EDGE_MASK;
            prev     <= hw_int;
        end
    end

endmodule

// File: tb/tb_cp0_timer_ext.sv
// Directed self-checking bench for cp0_timer_ext (6 lines, line 1 edge-triggered).
module tb_cp0_timer_ext;

    localparam int unsigned N = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        we;
    logic [29:0] pc;
    logic [4:0]  exc_code;
    logic        bd_in;
    logic        exl_clr;
    logic [N-1:0] hw_int;
    logic        int_exc_req;
    logic [31:0] epc;
    logic [31:0] rd_data;
    logic        timer_irq;

    int tests_run = 0;
    int tests_failed = 0;

    cp0_timer_ext #(
        .N_HWINT   (N),
        .EDGE_MASK (6'b000010),
        .PRID_VAL  (32'h2001_0616)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .we          (we),
        .pc          (pc),
        .exc_code    (exc_code),
        .bd_in       (bd_in),
        .exl_clr     (exl_clr),
        .hw_int      (hw_int),
        .int_exc_req (int_exc_req),
        .epc         (epc),
        .rd_data     (rd_data),
        .timer_irq   (timer_irq)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    endtask

    initial begin
        reset = 1'b1; rd_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'd0; we = 1'b0;
        pc = 30'd0; exc_code = 5'd0; bd_in = 1'b0; exl_clr = 1'b0; hw_int = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_epc", epc, 32'd0);
        chk("rst_timer_irq", {31'd0, timer_irq}, 32'd0);
        chk("rst_req", {31'd0, int_exc_req}, 32'd0);
        chk_reg("prid", 5'd15, 32'h2001_0616);
        chk_reg("rst_sr", 5'd12, 32'd0);
        chk_reg("unmapped_rd", 5'd3, 32'd0);

        // 1. level interrupt on line 0
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; pc = 30'h0C00; bd_in = 1'b0;
        #1;
        chk("lvl_req", {31'd0, int_exc_req}, 32'd1);
        tick();
        hw_int = '0;
        chk_reg("lvl_cause", 5'd13, 32'h0000_0400);
        chk_reg("lvl_sr_exl", 5'd12, 32'h0000_0403);
        chk("lvl_epc", epc, 32'h0000_3000);
        chk("lvl_req_masked_by_exl", {31'd0, int_exc_req}, 32'd0);
        exl_clr = 1'b1; tick(); exl_clr = 1'b0;
        chk_reg("eret_sr", 5'd12, 32'h0000_0401);

        // 2. edge line 1 with IE=0
        mtc0(5'd12, 32'h0000_0800);
        hw_int = 6'b000010; tick();
        hw_int = '0; tick();
        chk_reg("edge_ip_set", 5'd13, 32'h0000_0800);
        chk("edge_no_req_ie0", {31'd0, int_exc_req}, 32'd0);
        tick(); tick();
        chk_reg("edge_sticky", 5'd13, 32'h0000_0800);
        mtc0(5'd13, 32'h0000_0000);
        tick();
        chk_reg("edge_cleared", 5'd13, 32'h0000_0000);
        // rising edge and clear in the same cycle: set wins
        hw_int = 6'b000010;
        mtc0(5'd13, 32'h0000_0000);
        hw_int = '0;
        tick();
        chk_reg("edge_set_beats_clr", 5'd13, 32'h0000_0800);
        mtc0(5'd13, 32'h0000_0000);
        tick();
        chk_reg("edge_cleared2", 5'd13, 32'h0000_0000);

        // 3. timer
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd10);
        chk_reg("cnt_after_cmp_wr", 5'd9, 32'd1);
        chk_reg("cmp_rd", 5'd11, 32'd10);
        for (int i = 0; i < 8; i++) tick();
        chk_reg("cnt_9", 5'd9, 32'd9);
        chk("tmr_idle_9", {31'd0, timer_irq}, 32'd0);
        tick();
        chk_reg("cnt_10", 5'd9, 32'd10);
        chk("tmr_idle_10", {31'd0, timer_irq}, 32'd0);
        tick();
        chk("tmr_set", {31'd0, timer_irq}, 32'd1);
        tick(); tick(); tick();
        chk("tmr_sticky", {31'd0, timer_irq}, 32'd1);
        chk_reg("tmr_ip", 5'd13, 32'h0001_0000);
        mtc0(5'd11, 32'h1000_0000);
        chk("tmr_cleared", {31'd0, timer_irq}, 32'd0);

        // 4. exception in a delay slot, then interrupt beats exception
        exc_code = 5'd4; pc = 30'h1001; bd_in = 1'b1;
        #1;
        chk("exc_req", {31'd0, int_exc_req}, 32'd1);
        tick();
        exc_code = 5'd0; pc = 30'd0; bd_in = 1'b0;
        chk_reg("exc_cause", 5'd13, 32'h8000_0010);
        chk("exc_epc_bd", epc, 32'h0000_4000);
        exl_clr = 1'b1; tick(); exl_clr = 1'b0;
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; exc_code = 5'd4; pc = 30'h2000;
        tick();
        hw_int = '0; exc_code = 5'd0;
        chk_reg("int_beats_exc", 5'd13, 32'h0000_0400);
        chk("int_beats_exc_epc", epc, 32'h0000_8000);

        // 5. eret and take together; mtc0 during take is dropped
        exl_clr = 1'b1; tick(); exl_clr = 1'b0;
        exl_clr = 1'b1; exc_code = 5'd8; pc = 30'h3000;
        we = 1'b1; wr_addr = 5'd14; wr_data = 32'hDEAD_BEE0;
        tick();
        exl_clr = 1'b0; exc_code = 5'd0; we = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        chk_reg("take_beats_eret", 5'd12, 32'h0000_0403);
        chk("take_epc_not_mtc0", epc, 32'h0000_C000);
        chk_reg("take_cause", 5'd13, 32'h0000_0020);
        exl_clr = 1'b1; tick(); exl_clr = 1'b0;
        exc_code = 5'd2; pc = 30'h0010;
        mtc0(5'd12, 32'h0000_0000);
        exc_code = 5'd0;
        chk_reg("sr_mtc0_dropped", 5'd12, 32'h0000_0403);
        chk("epc_2", epc, 32'h0000_0040);
        exl_clr = 1'b1; tick(); exl_clr = 1'b0;
        mtc0(5'd14, 32'h0000_1234);
        chk("epc_mtc0", epc, 32'h0000_1234);

        // 6. Count wrap, then reset with the timer latched
        mtc0(5'd9, 32'hFFFF_FFFF);
        chk_reg("cnt_max", 5'd9, 32'hFFFF_FFFF);
        tick();
        chk_reg("cnt_wrap", 5'd9, 32'd0);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd2);
        tick(); tick();
        chk("tmr_set_pre_rst", {31'd0, timer_irq}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_mid_tmr", {31'd0, timer_irq}, 32'd0);
        chk_reg("rst_mid_cnt", 5'd9, 32'd0);
        chk_reg("rst_mid_sr", 5'd12, 32'd0);
        chk("rst_mid_epc", epc, 32'd0);
        tick();
        chk_reg("cnt_after_rst", 5'd9, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
